usb_rfifo: RTL and testbench

Receive buffer directly downstream of the USB bit decoder. It collects the de-stuffed, NRZI-decoded serial bits of a DATA0/DATA1 packet (LSB first) into bytes and strips the trailing CRC16 bytes. On a good packet it presents the payload to the transaction layer through a byte-wide read port; on a failed packet it discards the payload. It reports `rfifo_full` back to the decoder so the decoder can abandon an oversize packet.

---
 rtl/usb_rfifo_pkg.sv | 7 +
 rtl/usb_rfifo_mem.sv | 42 ++++
 rtl/usb_rfifo.sv | 177 +++++++++++++++++
 tb/tb_usb_rfifo.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rfifo_pkg.sv
// Shared USB constants used by the receive path.
package usb_rfifo_pkg;

   localparam int USB_RFIFO_DEPTH = 128;
   localparam int USB_CRC16_BYTES = 2;

endpackage

// File: rtl/usb_rfifo_mem.sv
// Simple dual-port byte RAM: synchronous write, registered read with a
// clearable output register so the read port shows 0 after any clear.
module usb_rfifo_mem
   import usb_rfifo_pkg::*;
#(
   parameter  int DEPTH = USB_RFIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [DEPTH];
   logic [7:0] r_rdata;

   // NOTE: the storage array has no reset; only the read register is cleared, which keeps the array mappable to RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= 8'h00;
      end else if (i_clr) begin
         r_rdata <= 8'h00;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/usb_rfifo.sv
// USB receive FIFO: packs decoded payload bits (LSB first) into bytes, strips
// the CRC16 trailer on commit and serves the payload through a one-cycle read port.
module usb_rfifo
   import usb_rfifo_pkg::*;
#(
   parameter  int DEPTH = USB_RFIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst0_async,
   input  logic        rst0_sync,
   input  logic        rfifo_rst0,
   input  logic        rfifo_wr,
   input  logic        rfifo_wbit,
   input  logic        rfifo_commit,
   input  logic        rfifo_abort,
   output logic        rfifo_full,
   input  logic        rfifo_rd,
   output logic [7:0]  rfifo_rdata,
   output logic        rfifo_rvalid,
   output logic [AW:0] rfifo_avail,
   output logic        rfifo_ready,
   output logic        rfifo_err
);

   typedef enum logic [1:0] {
      RFIFO_EMPTY = 2'd0,
      RFIFO_FILL  = 2'd1,
      RFIFO_READY = 2'd2,
      RFIFO_DROP  = 2'd3
   } rfifo_state_t;

   localparam logic [AW:0]   WPTR_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] RPTR_ONE = AW'(1);
   localparam logic [AW:0]   CRC_LEN  = (AW+1)'(USB_CRC16_BYTES);

   rfifo_state_t  r_state;
   rfifo_state_t  w_state_nxt;
   logic [AW:0]   r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_avail;
   logic [2:0]    r_bitcnt;
   logic [6:0]    r_sr;
   logic          r_ovf;
   logic          r_err;
   logic          r_rvalid;

   logic          w_clr;
   logic          w_rx_state;
   logic          w_ctl_act;
   logic          w_wr_en;
   logic          w_bit_acc;
   logic          w_ovf_set;
   logic          w_byte_done;
   logic [7:0]    w_sr_nxt;
   logic          w_commit_ok;
   logic          w_commit_bad;
   logic          w_rd_acc;

   assign w_clr      = !rst0_sync || !rfifo_rst0;
   assign w_rx_state = (r_state == RFIFO_EMPTY) || (r_state == RFIFO_FILL);

   // A commit or abort that takes effect owns the cycle; a bit arriving with it is dropped.
   assign w_ctl_act    = w_rx_state && (rfifo_abort || (rfifo_commit && (r_state == RFIFO_FILL)));
   assign w_wr_en      = rfifo_wr && w_rx_state && !w_ctl_act;
   assign w_bit_acc    = w_wr_en && !rfifo_full;
   assign w_ovf_set    = w_wr_en && rfifo_full;
   assign w_byte_done  = w_bit_acc && (r_bitcnt == 3'd7);
   assign w_sr_nxt     = {rfifo_wbit, r_sr};

   assign w_commit_ok  = (r_state == RFIFO_FILL) && rfifo_commit && !rfifo_abort && !r_ovf;
   assign w_commit_bad = (r_state == RFIFO_FILL) && rfifo_commit && !rfifo_abort && r_ovf;
   assign w_rd_acc     = rfifo_rd && (r_state == RFIFO_READY) && (r_avail != '0);

   // NOTE: defaults are assigned first so every path drives w_state_nxt and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RFIFO_EMPTY: begin
            if (rfifo_abort) begin
               w_state_nxt = RFIFO_DROP;
            end else if (rfifo_wr) begin
               w_state_nxt = RFIFO_FILL;
            end
         end
         RFIFO_FILL: begin
            if (rfifo_abort) begin
               w_state_nxt = RFIFO_DROP;
            end else if (rfifo_commit) begin
               w_state_nxt = r_ovf ? RFIFO_DROP : RFIFO_READY;
            end
         end
         default: begin
            w_state_nxt = r_state;
         end
      endcase
      if (w_clr) begin
         w_state_nxt = RFIFO_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst0_async) begin
      if (!rst0_async) begin
         r_state <= RFIFO_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst0_async) begin
      if (!rst0_async) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_avail  <= '0;
         r_bitcnt <= '0;
         r_sr     <= '0;
         r_ovf    <= 1'b0;
         r_err    <= 1'b0;
         r_rvalid <= 1'b0;
      end else if (w_clr) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_avail  <= '0;
         r_bitcnt <= '0;
         r_sr     <= '0;
         r_ovf    <= 1'b0;
         r_err    <= 1'b0;
         r_rvalid <= 1'b0;
      end else begin
         if (w_bit_acc) begin
            r_sr     <= w_sr_nxt[7:1];
            r_bitcnt <= r_bitcnt + 3'd1;
         end
         if (w_byte_done) begin
            r_wptr <= r_wptr + WPTR_ONE;
         end
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end
         // The last two stored bytes are the CRC16 trailer; a trailing partial byte was never stored.
         if (w_commit_ok) begin
            r_avail <= (r_wptr >= CRC_LEN) ? (r_wptr - CRC_LEN) : '0;
         end
         if (w_commit_bad) begin
            r_err <= 1'b1;
         end
         if (w_rd_acc) begin
            r_rptr  <= r_rptr + RPTR_ONE;
            r_avail <= r_avail - WPTR_ONE;
         end
         r_rvalid <= w_rd_acc;
      end
   end

   usb_rfifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst0_async),
      .i_clr   (w_clr),
      .i_we    (w_byte_done),
      .i_waddr (r_wptr[AW-1:0]),
      .i_wdata (w_sr_nxt),
      .i_re    (w_rd_acc),
      .i_raddr (r_rptr),
      .o_rdata (rfifo_rdata)
   );

   // The top wptr bit is set only when all DEPTH bytes are stored, since writes stop there.
   assign rfifo_full   = r_wptr[AW];
   assign rfifo_rvalid = r_rvalid;
   assign rfifo_avail  = r_avail;
   assign rfifo_ready  = (r_state == RFIFO_READY);
   assign rfifo_err    = r_err;

endmodule

// File: tb/tb_usb_rfifo.sv
// Bench for usb_rfifo: directed scenarios with literal expectations plus
// randomized packets, all outputs compared every cycle against a queue-based model.
module tb_usb_rfifo;

   localparam int DEPTH = 128;
   localparam int AW    = 7;

   logic          clk = 1'b0;
   logic          rst0_async;
   logic          rst0_sync;
   logic          rfifo_rst0;
   logic          rfifo_wr;
   logic          rfifo_wbit;
   logic          rfifo_commit;
   logic          rfifo_abort;
   logic          rfifo_rd;
   logic          rfifo_full;
   logic [7:0]    rfifo_rdata;
   logic          rfifo_rvalid;
   logic [AW:0]   rfifo_avail;
   logic          rfifo_ready;
   logic          rfifo_err;

   int n_pass  = 0;
   int n_total = 0;

   usb_rfifo #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst0_async   (rst0_async),
      .rst0_sync    (rst0_sync),
      .rfifo_rst0   (rfifo_rst0),
      .rfifo_wr     (rfifo_wr),
      .rfifo_wbit   (rfifo_wbit),
      .rfifo_commit (rfifo_commit),
      .rfifo_abort  (rfifo_abort),
      .rfifo_full   (rfifo_full),
      .rfifo_rd     (rfifo_rd),
      .rfifo_rdata  (rfifo_rdata),
      .rfifo_rvalid (rfifo_rvalid),
      .rfifo_avail  (rfifo_avail),
      .rfifo_ready  (rfifo_ready),
      .rfifo_err    (rfifo_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_RX, M_READY, M_DROP} mphase_t;
   mphase_t    m_phase  = M_IDLE;
   bit         m_bits[$];
   logic [7:0] m_bytes[$];
   bit         m_ovf    = 1'b0;
   bit         m_err    = 1'b0;
   bit         m_rvalid = 1'b0;
   int         m_avail  = 0;
   int         m_rd_idx = 0;
   logic [7:0] m_rdata  = 8'h00;

   function automatic void model_clear();
      m_phase  = M_IDLE;
      m_bits.delete();
      m_bytes.delete();
      m_ovf    = 1'b0;
      m_err    = 1'b0;
      m_rvalid = 1'b0;
      m_avail  = 0;
      m_rd_idx = 0;
      m_rdata  = 8'h00;
   endfunction

   function automatic void model_step();
      logic [7:0] b;
      bit         rv;
      rv = 1'b0;
      if (!rst0_sync || !rfifo_rst0) begin
         model_clear();
         return;
      end
      if (m_phase == M_IDLE || m_phase == M_RX) begin
         if (rfifo_abort) begin
            m_phase = M_DROP;
         end else if (rfifo_commit && m_phase == M_RX) begin
            if (m_ovf) begin
               m_phase = M_DROP;
               m_err   = 1'b1;
            end else begin
               m_phase = M_READY;
               m_avail = (m_bytes.size() >= 2) ? m_bytes.size() - 2 : 0;
            end
         end else if (rfifo_wr) begin
            m_phase = M_RX;
            if (m_bytes.size() == DEPTH) begin
               m_ovf = 1'b1;
            end else begin
               m_bits.push_back(rfifo_wbit);
               if (m_bits.size() == 8) begin
                  b = 8'h00;
                  for (int i = 0; i < 8; i++) b[i] = m_bits[i];
                  m_bytes.push_back(b);
                  m_bits.delete();
               end
            end
         end
      end else if (m_phase == M_READY) begin
         if (rfifo_rd && m_avail > 0) begin
            m_rdata = m_bytes[m_rd_idx];
            m_rd_idx++;
            m_avail--;
            rv = 1'b1;
         end
      end
      m_rvalid = rv;
   endfunction

   always @(posedge clk or negedge rst0_async) begin
      if (!rst0_async) model_clear();
      else             model_step();
   end

   // Single compare process: every output, every cycle, on the falling edge.
   always @(negedge clk) begin
      check("cyc_full",   rfifo_full,   (m_bytes.size() == DEPTH));
      check("cyc_rvalid", rfifo_rvalid, m_rvalid);
      check("cyc_rdata",  rfifo_rdata,  m_rdata);
      check("cyc_avail",  rfifo_avail,  m_avail);
      check("cyc_ready",  rfifo_ready,  (m_phase == M_READY));
      check("cyc_err",    rfifo_err,    m_err);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_idle();
      rfifo_wr     = 1'b0;
      rfifo_wbit   = 1'b0;
      rfifo_commit = 1'b0;
      rfifo_abort  = 1'b0;
      rfifo_rd     = 1'b0;
      rfifo_rst0   = 1'b1;
   endtask

   task automatic clear_pkt();
      rfifo_rst0 = 1'b0;
      tick();
      rfifo_rst0 = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         rfifo_wr   = 1'b1;
         rfifo_wbit = b[i];
         tick();
      end
      rfifo_wr = 1'b0;
   endtask

   task automatic pulse_commit();
      rfifo_commit = 1'b1;
      tick();
      rfifo_commit = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_full"},   rfifo_full,   0);
      check({tag, "_rvalid"}, rfifo_rvalid, 0);
      check({tag, "_rdata"},  rfifo_rdata,  0);
      check({tag, "_avail"},  rfifo_avail,  0);
      check({tag, "_ready"},  rfifo_ready,  0);
      check({tag, "_err"},    rfifo_err,    0);
   endtask

   initial begin
      int nbits;
      int kind;
      int ncyc;

      rst0_async = 1'b0;
      rst0_sync  = 1'b1;
      set_idle();
      repeat (3) @(posedge clk);
      #2;
      check_all_zero("reset");
      rst0_async = 1'b1;
      tick();
      check_all_zero("post_reset");

      // Normal packet: two payload bytes plus two CRC bytes.
      clear_pkt();
      send_byte(8'h11); send_byte(8'h22); send_byte(8'hAB); send_byte(8'hCD);
      pulse_commit();
      check("norm_ready", rfifo_ready, 1);
      check("norm_avail", rfifo_avail, 2);
      check("norm_err",   rfifo_err,   0);
      rfifo_rd = 1'b1;
      tick();
      check("norm_rv0", rfifo_rvalid, 1);
      check("norm_rd0", rfifo_rdata,  8'h11);
      tick();
      check("norm_rv1",    rfifo_rvalid, 1);
      check("norm_rd1",    rfifo_rdata,  8'h22);
      check("norm_avail0", rfifo_avail,  0);
      tick();
      check("norm_rv_end",  rfifo_rvalid, 0);
      check("norm_hold",    rfifo_rdata,  8'h22);
      check("norm_sticky",  rfifo_ready,  1);
      rfifo_rd = 1'b0;

      // Abort after 24 bits.
      clear_pkt();
      send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h3C);
      rfifo_abort = 1'b1;
      tick();
      rfifo_abort = 1'b0;
      check("abort_ready", rfifo_ready, 0);
      check("abort_err",   rfifo_err,   0);
      rfifo_rd = 1'b1;
      tick();
      rfifo_rd = 1'b0;
      check("abort_rv", rfifo_rvalid, 0);

      // Overflow: 129 bytes into 128 bytes of storage.
      clear_pkt();
      for (int i = 0; i < DEPTH - 1; i++) send_byte(8'(i));
      check("ovf_full127", rfifo_full, 0);
      send_byte(8'hEE);
      check("ovf_full128", rfifo_full, 1);
      send_byte(8'h77);
      pulse_commit();
      check("ovf_err",   rfifo_err,   1);
      check("ovf_ready", rfifo_ready, 0);
      check("ovf_full",  rfifo_full,  1);
      rfifo_rst0 = 1'b0;
      tick();
      rfifo_rst0 = 1'b1;
      check("ovf_clr_full", rfifo_full, 0);
      check("ovf_clr_err",  rfifo_err,  0);

      // Zero-length payload: CRC only.
      clear_pkt();
      send_byte(8'h0F); send_byte(8'hF0);
      pulse_commit();
      check("zl_ready", rfifo_ready, 1);
      check("zl_avail", rfifo_avail, 0);
      rfifo_rd = 1'b1;
      tick();
      rfifo_rd = 1'b0;
      check("zl_rv", rfifo_rvalid, 0);

      // Commit and abort together: abort wins; later commit ignored in DROP.
      clear_pkt();
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      rfifo_commit = 1'b1;
      rfifo_abort  = 1'b1;
      tick();
      rfifo_abort = 1'b0;
      check("both_ready", rfifo_ready, 0);
      check("both_err",   rfifo_err,   0);
      tick();
      rfifo_commit = 1'b0;
      check("drop_commit_ready", rfifo_ready, 0);

      // Commit in EMPTY is ignored; the packet still completes normally.
      clear_pkt();
      pulse_commit();
      check("empty_commit_ready", rfifo_ready, 0);
      send_byte(8'h9C); send_byte(8'h12); send_byte(8'h34);
      pulse_commit();
      check("empty_commit_ready2", rfifo_ready, 1);
      check("empty_commit_avail",  rfifo_avail, 1);

      // Clear in the middle of a read stream.
      clear_pkt();
      for (int i = 1; i <= 6; i++) send_byte(8'(i));
      pulse_commit();
      check("rs_avail", rfifo_avail, 4);
      rfifo_rd = 1'b1;
      tick();
      check("rs_rd0", rfifo_rdata, 8'h01);
      rfifo_rst0 = 1'b0;
      tick();
      rfifo_rst0 = 1'b1;
      rfifo_rd   = 1'b0;
      check_all_zero("rs_clr");

      // Synchronous reset clears a committed packet.
      clear_pkt();
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
      pulse_commit();
      rst0_sync = 1'b0;
      tick();
      rst0_sync = 1'b1;
      check_all_zero("sync_rst");

      // Asynchronous reset mid-FILL, checked before any clock edge.
      clear_pkt();
      for (int i = 0; i < DEPTH; i++) send_byte(8'(i * 3));
      check("async_pre_full", rfifo_full, 1);
      rfifo_wr   = 1'b1;
      rfifo_wbit = 1'b1;
      tick();
      #1 rst0_async = 1'b0;
      #1 check_all_zero("async_rst");
      set_idle();
      tick();
      rst0_async = 1'b1;
      tick();
      check_all_zero("async_rel");

      // Randomized packets checked by the per-cycle compare process.
      for (int p = 0; p < 40; p++) begin
         set_idle();
         clear_pkt();
         if ($urandom_range(0, 9) == 0) nbits = $urandom_range(DEPTH * 8 - 16, DEPTH * 8 + 40);
         else                           nbits = $urandom_range(0, 90);
         for (int i = 0; i < nbits; i++) begin
            rfifo_wr     = ($urandom_range(0, 4) != 0);
            rfifo_wbit   = 1'($urandom);
            rfifo_rd     = 1'($urandom);
            rfifo_commit = ($urandom_range(0, 199) == 0);
            rfifo_abort  = ($urandom_range(0, 299) == 0);
            tick();
         end
         set_idle();
         kind = $urandom_range(0, 9);
         rfifo_commit = (kind <= 6) || (kind == 8);
         rfifo_abort  = (kind >= 7 && kind <= 8);
         rfifo_rst0   = (kind != 9);
         tick();
         set_idle();
         ncyc = $urandom_range(2, 30);
         for (int c = 0; c < ncyc; c++) begin
            rfifo_rd   = ($urandom_range(0, 3) != 0);
            rfifo_wr   = ($urandom_range(0, 7) == 0);
            rfifo_rst0 = ($urandom_range(0, 39) != 0);
            tick();
         end
      end

      set_idle();
      tick();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
